fetch_pc_unit: RTL

Program-counter and next-PC stage of the single-cycle MIPS core. It drives the byte address into the instruction memory and takes back the 32-bit big-endian instruction word. From that word it selects the next PC: sequential, beq/bne, j/jal or jr. It stops the core cleanly at the end of the program image and sticks in a fault state on any bad control-transfer target.

---
 rtl/mips_pkg.sv | 18 +
 rtl/next_pc_logic.sv | 53 +++++
 rtl/fetch_pc_unit.sv | 67 ++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared decode constants and fetch-stage state type for the single-cycle MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: decodes the fetched word, picks the target
// and reports whether it is a control transfer and whether the target is fetchable.
module next_pc_logic
    import mips_pkg::*;
#(
    parameter int MEM_BYTES = 100
) (
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] target,
    output logic        is_ctrl,
    output logic        target_ok
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] br_offset;
    logic        is_jr;
    logic        is_jump;
    logic        br_taken;

    assign op        = inst[31:26];
    assign funct     = inst[5:0];
    assign pc_plus4  = pc + 32'd4;
    assign br_offset = {{14{inst[15]}}, inst[15:0], 2'b00};

    assign is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
    assign is_jump  = (op == OP_J) || (op == OP_JAL);
    assign br_taken = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);

    // A not-taken branch counts as sequential, so running off the end there halts.
    assign is_ctrl = is_jr || is_jump || br_taken;

    always_comb begin
        // NOTE: default first so every path assigns target and no latch is inferred.
        target = pc_plus4;
        if (is_jr) begin
            target = rs_data;
        end else if (is_jump) begin
            target = {pc_plus4[31:28], inst[25:0], 2'b00};
        end else if (br_taken) begin
            target = pc_plus4 + br_offset;
        end
    end

    assign target_ok = (target[1:0] == 2'b00) && (target <= LAST_WORD);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter stage: holds pc, retired-instruction count and the sticky
// HALT/FAULT state; the next-PC choice comes from next_pc_logic.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter int          MEM_BYTES = 100,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] inst_count
);

    fetch_state_t state;
    logic [31:0]  target;
    logic         is_ctrl;
    logic         target_ok;

    next_pc_logic #(
        .MEM_BYTES(MEM_BYTES)
    ) u_next_pc (
        .pc       (pc),
        .inst     (inst),
        .zero     (zero),
        .rs_data  (rs_data),
        .pc_plus4 (pc_plus4),
        .target   (target),
        .is_ctrl  (is_ctrl),
        .target_ok(target_ok)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= ST_RUN;
            pc         <= RESET_PC;
            halted     <= 1'b0;
            fault      <= 1'b0;
            fault_pc   <= 32'h0;
            inst_count <= 32'h0;
        end else if (state == ST_RUN && !stall) begin
            if (target_ok) begin
                pc         <= target;
                inst_count <= inst_count + 32'd1;
            end else if (!is_ctrl) begin
                // Falling off the image sequentially is the normal end of program.
                state      <= ST_HALT;
                halted     <= 1'b1;
                inst_count <= inst_count + 32'd1;
            end else begin
                state      <= ST_FAULT;
                fault      <= 1'b1;
                fault_pc   <= target;
            end
        end
    end

endmodule
